// File: rtl/knn_ctrl_pkg.sv
// Shared state encoding and width helpers for the KNN job controller and its result FIFO.
package knn_ctrl_pkg;

  localparam int unsigned NameWidth = 32;

  typedef enum logic [2:0] {
    StIdle,
    StClear,
    StLoad,
    StStream,
    StCollect
  } state_e;

  // Counter width for values 0..n-1, never below one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned res_width(input int unsigned data_width);
    return NameWidth + data_width;
  endfunction

endpackage

// File: rtl/knn_result_fifo.sv
// First-word-fall-through result buffer; read data comes straight from the storage registers.
module knn_result_fifo
  import knn_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned WIDTH = 64
) (
  input  logic             mclk,
  input  logic             reset,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PtrW = cnt_width(DEPTH);
  localparam int unsigned CntW = cnt_width(DEPTH + 1);
  // Storage rounded up to the pointer range so every pointer value indexes a real entry.
  localparam int unsigned MemDepth = 2 ** PtrW;
  localparam logic [PtrW-1:0] PtrLast = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [WIDTH-1:0] r_mem [MemDepth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CntFull);
  assign w_rd    = i_rd & ~o_empty;
  assign w_wr    = i_wr & (~o_full | w_rd);
  assign o_rdata = r_mem[r_rd_ptr];

  always_ff @(posedge mclk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge mclk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= (r_wr_ptr == PtrLast) ? '0 : r_wr_ptr + PtrW'(1);
      end
      if (w_rd) begin
        r_rd_ptr <= (r_rd_ptr == PtrLast) ? '0 : r_rd_ptr + PtrW'(1);
      end
      if (w_wr && !w_rd) begin
        r_count <= r_count + CntW'(1);
      end else if (!w_wr && w_rd) begin
        r_count <= r_count - CntW'(1);
      end
    end
  end

endmodule

// File: rtl/knn_job_ctrl.sv
// Job sequencer in front of the KNN core: frames the query stream, pulses core reset per job and
// replays the K core results as an AXI-Stream. Define KNN_PERF_CNT_EN to add perf_cycles.
module knn_job_ctrl
  import knn_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DIMENSIONS   = 32,
  parameter int unsigned K            = 1,
  parameter int unsigned PT_W         = 16,
  parameter int unsigned CLEAR_CYCLES = 2
) (
  input  logic                            mclk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [PT_W-1:0]                 num_points,
  input  logic [DATA_WIDTH-1:0]           s_tdata,
  input  logic                            s_tvalid,
  output logic                            s_tready,
  input  logic                            s_tlast,
  output logic                            core_reset,
  output logic                            core_wr_en,
  output logic [DATA_WIDTH-1:0]           core_data,
  output logic                            core_last,
  input  logic                            core_out_wr_en,
  input  logic [NameWidth-1:0]            core_name,
  input  logic [DATA_WIDTH-1:0]           core_value,
  output logic [NameWidth+DATA_WIDTH-1:0] m_tdata,
  output logic                            m_tvalid,
  input  logic                            m_tready,
  output logic                            m_tlast,
  output logic                            busy,
  output logic                            done,
`ifdef KNN_PERF_CNT_EN
  output logic [31:0]                     perf_cycles,
`endif
  output logic                            err_frame
);

  localparam int unsigned WordW   = cnt_width(DIMENSIONS);
  localparam int unsigned ResCntW = cnt_width(K + 1);
  localparam int unsigned ClrW    = cnt_width(CLEAR_CYCLES);
  localparam int unsigned ResW    = res_width(DATA_WIDTH);
  localparam logic [WordW-1:0]   WordLast = WordW'(DIMENSIONS - 1);
  localparam logic [ResCntW-1:0] ResLast  = ResCntW'(K - 1);
  localparam logic [ResCntW-1:0] ResAll   = ResCntW'(K);
  localparam logic [ClrW-1:0]    ClrLast  = ClrW'(CLEAR_CYCLES - 1);

  state_e             r_state;
  logic [ClrW-1:0]    r_clr_cnt;
  logic [WordW-1:0]   r_word_cnt;
  logic [PT_W-1:0]    r_pt_cnt;
  logic [PT_W-1:0]    r_num_pts;
  logic [ResCntW-1:0] r_rcvd;
  logic [ResCntW-1:0] r_sent;
  logic               r_zero_job;
  logic               r_err;

  logic w_beat;
  logic w_word_last;
  logic w_final;
  logic w_fifo_wr;
  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_m_hs;
  logic w_last_res;
  logic w_done;

  assign s_tready    = (r_state == StLoad) || (r_state == StStream);
  assign w_beat      = s_tvalid & s_tready;
  assign w_word_last = (r_word_cnt == WordLast);
  assign w_final     = (r_state == StStream) && w_word_last &&
                       (r_pt_cnt == r_num_pts - PT_W'(1));

  assign core_wr_en = w_beat;
  assign core_data  = s_tdata;
  // An early tlast also terminates the core's job so it still produces results.
  assign core_last  = w_beat & (w_final | s_tlast);
  assign core_reset = reset | (r_state == StClear);

  assign w_fifo_wr  = (r_state == StCollect) & ~r_zero_job & core_out_wr_en &
                      (r_rcvd != ResAll) & (~w_fifo_full | w_m_hs);
  assign m_tvalid   = ~w_fifo_empty;
  assign w_m_hs     = m_tvalid & m_tready;
  assign w_last_res = (r_sent == ResLast);
  assign m_tlast    = m_tvalid & w_last_res;
  assign w_done     = (r_state == StCollect) & (r_zero_job | (w_m_hs & w_last_res));

  assign done      = w_done;
  assign busy      = (r_state != StIdle);
  assign err_frame = r_err;

  always_ff @(posedge mclk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_clr_cnt  <= '0;
      r_word_cnt <= '0;
      r_pt_cnt   <= '0;
      r_num_pts  <= '0;
      r_rcvd     <= '0;
      r_sent     <= '0;
      r_zero_job <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (start) begin
            r_num_pts  <= num_points;
            r_clr_cnt  <= '0;
            r_word_cnt <= '0;
            r_pt_cnt   <= '0;
            r_rcvd     <= '0;
            r_sent     <= '0;
            r_zero_job <= (num_points == '0);
            r_err      <= (num_points == '0);
            r_state    <= (num_points == '0) ? StCollect : StClear;
          end
        end
        StClear: begin
          if (r_clr_cnt == ClrLast) begin
            r_state <= StLoad;
          end else begin
            r_clr_cnt <= r_clr_cnt + ClrW'(1);
          end
        end
        StLoad, StStream: begin
          if (w_beat) begin
            // Framing is good only when tlast coincides exactly with the final beat.
            if (s_tlast != w_final) begin
              r_err <= 1'b1;
            end
            if (s_tlast || w_final) begin
              r_state <= StCollect;
            end else if (w_word_last) begin
              r_word_cnt <= '0;
              if (r_state == StStream) begin
                r_pt_cnt <= r_pt_cnt + PT_W'(1);
              end
              r_state <= StStream;
            end else begin
              r_word_cnt <= r_word_cnt + WordW'(1);
            end
          end
        end
        StCollect: begin
          if (w_fifo_wr) begin
            r_rcvd <= r_rcvd + ResCntW'(1);
          end
          if (w_m_hs) begin
            r_sent <= r_sent + ResCntW'(1);
          end
          if (w_done) begin
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

`ifdef KNN_PERF_CNT_EN
  logic [31:0] r_perf_cycles;

  always_ff @(posedge mclk) begin
    if (reset) begin
      r_perf_cycles <= '0;
    end else if (r_state == StIdle) begin
      if (start) begin
        r_perf_cycles <= '0;
      end
    end else if (r_perf_cycles != 32'hFFFF_FFFF) begin
      r_perf_cycles <= r_perf_cycles + 32'd1;
    end
  end

  assign perf_cycles = r_perf_cycles;
`endif

  knn_result_fifo #(
    .DEPTH(K),
    .WIDTH(ResW)
  ) u_result_fifo (
    .mclk   (mclk),
    .reset  (reset),
    .i_wr   (w_fifo_wr),
    .i_wdata({core_name, core_value}),
    .i_rd   (w_m_hs),
    .o_rdata(m_tdata),
    .o_full (w_fifo_full),
    .o_empty(w_fifo_empty)
  );

endmodule

// File: tb/tb_knn_job_ctrl.sv
// Directed bench for knn_job_ctrl (DIMENSIONS=4, K=2): job table plus hand-written corner cases.
module tb_knn_job_ctrl;

  logic        mclk;
  logic        reset;
  logic        start;
  logic [15:0] num_points;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tlast;
  logic        core_reset;
  logic        core_wr_en;
  logic [31:0] core_data;
  logic        core_last;
  logic        core_out_wr_en;
  logic [31:0] core_name;
  logic [31:0] core_value;
  logic [63:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tlast;
  logic        busy;
  logic        done;
  logic        err_frame;
`ifdef KNN_PERF_CNT_EN
  logic [31:0] perf_cycles;
`endif

  knn_job_ctrl #(
    .DATA_WIDTH  (32),
    .DIMENSIONS  (4),
    .K           (2),
    .PT_W        (16),
    .CLEAR_CYCLES(2)
  ) dut (
    .mclk          (mclk),
    .reset         (reset),
    .start         (start),
    .num_points    (num_points),
    .s_tdata       (s_tdata),
    .s_tvalid      (s_tvalid),
    .s_tready      (s_tready),
    .s_tlast       (s_tlast),
    .core_reset    (core_reset),
    .core_wr_en    (core_wr_en),
    .core_data     (core_data),
    .core_last     (core_last),
    .core_out_wr_en(core_out_wr_en),
    .core_name     (core_name),
    .core_value    (core_value),
    .m_tdata       (m_tdata),
    .m_tvalid      (m_tvalid),
    .m_tready      (m_tready),
    .m_tlast       (m_tlast),
    .busy          (busy),
    .done          (done),
`ifdef KNN_PERF_CNT_EN
    .perf_cycles   (perf_cycles),
`endif
    .err_frame     (err_frame)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  int checks = 0;
  int failures = 0;

  // Observed-event counters, sampled on the falling edge.
  int wr_tot = 0, last_tot = 0, last_at = 0, data_bad = 0, m_tot = 0, done_tot = 0, busy_tot = 0;
  logic [63:0] m_data [0:63];
  logic        m_last [0:63];

  always @(negedge mclk) begin
    if (core_wr_en) begin
      wr_tot++;
      if (core_data !== s_tdata) data_bad++;
      if (core_last) last_at = wr_tot;
    end
    if (core_last) last_tot++;
    if (m_tvalid && m_tready) begin
      if (m_tot < 64) begin
        m_data[m_tot] = m_tdata;
        m_last[m_tot] = m_tlast;
      end
      m_tot++;
    end
    if (done) done_tot++;
    if (busy) busy_tot++;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] np;
    int          tl;
    bit          toggle;
    bit          stall;
    int          beats;
    bit          exp_err;
    logic [31:0] nm0;
    logic [31:0] v0;
    logic [31:0] nm1;
    logic [31:0] v1;
  } job_t;

  job_t jobs [6];

  task automatic do_start(input logic [15:0] np);
    start = 1'b1;
    num_points = np;
    @(posedge mclk); #1;
    start = 1'b0;
  endtask

  task automatic send_beats(input int n, input int tl, input bit toggle);
    int i;
    int cyc;
    i = 1;
    cyc = 0;
    while (i <= n && cyc < 2000) begin
      s_tvalid = toggle ? cyc[0] : 1'b1;
      s_tdata  = 32'hA000_0000 + 32'(i) + 32'(cyc << 8);
      s_tlast  = (i == tl);
      @(negedge mclk);
      if (s_tvalid && s_tready) i++;
      @(posedge mclk); #1;
      cyc++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    check("stream_beats_accepted", 64'(i - 1), 64'(n));
  endtask

  task automatic drive_results(input logic [31:0] n0, v0, n1, v1);
    core_out_wr_en = 1'b1; core_name = n0; core_value = v0;
    @(posedge mclk); #1;
    core_out_wr_en = 1'b0;
    @(posedge mclk); #1;
    core_out_wr_en = 1'b1; core_name = n1; core_value = v1;
    @(posedge mclk); #1;
    // Surplus strobe: must be dropped.
    core_out_wr_en = 1'b1; core_name = 32'hDEAD_0000; core_value = 32'hBEEF_0000;
    @(posedge mclk); #1;
    core_out_wr_en = 1'b0;
  endtask

  task automatic wait_done(input int d0);
    int c;
    c = 0;
    while (done_tot == d0 && c < 200) begin
      @(posedge mclk); #1;
      c++;
    end
    check("done_seen", 64'(done_tot != d0), 64'd1);
  endtask

  task automatic job_body(input job_t j, input bit stall, input bit poke_start);
    int w0, l0, m0, d0, b0;
    w0 = wr_tot; l0 = last_tot; m0 = m_tot; d0 = done_tot; b0 = data_bad;
    send_beats(j.beats, j.tl, j.toggle);
    @(negedge mclk);
    check("s_tready_after_final", 64'(s_tready), 64'd0);
    check("busy_in_collect", 64'(busy), 64'd1);
    @(posedge mclk); #1;
    if (poke_start) begin
      start = 1'b1; num_points = 16'd0;
      @(posedge mclk); #1;
      start = 1'b0; num_points = 16'd3;
    end
    m_tready = !stall;
    drive_results(j.nm0, j.v0, j.nm1, j.v1);
    if (stall) begin
      repeat (20) begin
        @(posedge mclk); #1;
      end
      @(negedge mclk);
      check("stall_m_tvalid", 64'(m_tvalid), 64'd1);
      check("stall_no_beats", 64'(m_tot - m0), 64'd0);
      check("stall_no_done", 64'(done_tot - d0), 64'd0);
      @(posedge mclk); #1;
      m_tready = 1'b1;
    end
    wait_done(d0);
    @(negedge mclk);
    check("wr_en_count", 64'(wr_tot - w0), 64'(j.beats));
    check("core_last_count", 64'(last_tot - l0), 64'd1);
    check("core_last_beat", 64'(last_at - w0), 64'(j.beats));
    check("core_data_passthru", 64'(data_bad - b0), 64'd0);
    check("m_beat_count", 64'(m_tot - m0), 64'd2);
    check("m_data_first", m_data[m0], {j.nm0, j.v0});
    check("m_data_second", m_data[m0 + 1], {j.nm1, j.v1});
    check("m_tlast_first", 64'(m_last[m0]), 64'd0);
    check("m_tlast_second", 64'(m_last[m0 + 1]), 64'd1);
    check("done_count", 64'(done_tot - d0), 64'd1);
    check("err_frame", 64'(err_frame), 64'(j.exp_err));
    check("busy_after_done", 64'(busy), 64'd0);
    @(posedge mclk); #1;
  endtask

  initial begin
    int w0, d0, b0;
    reset = 1'b1; start = 1'b0; num_points = '0;
    s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
    core_out_wr_en = 1'b0; core_name = '0; core_value = '0; m_tready = 1'b1;

    jobs[0] = '{16'd3, 16, 1'b0, 1'b0, 16, 1'b0, 32'd7,  32'h100, 32'd2,  32'h180};
    jobs[1] = '{16'd3, 9,  1'b0, 1'b0, 9,  1'b1, 32'd11, 32'h200, 32'd12, 32'h201};
    jobs[2] = '{16'd3, 0,  1'b0, 1'b0, 16, 1'b1, 32'd21, 32'h300, 32'd20, 32'h310};
    jobs[3] = '{16'd1, 8,  1'b1, 1'b0, 8,  1'b0, 32'd31, 32'h400, 32'd30, 32'h401};
    jobs[4] = '{16'd2, 3,  1'b0, 1'b0, 3,  1'b1, 32'd41, 32'h500, 32'd40, 32'h5FF};
    jobs[5] = '{16'd3, 16, 1'b1, 1'b1, 16, 1'b0, 32'd51, 32'h600, 32'd52, 32'h650};

    repeat (3) @(posedge mclk);
    @(negedge mclk);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_core_wr_en", 64'(core_wr_en), 64'd0);
    check("rst_core_last", 64'(core_last), 64'd0);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err_frame", 64'(err_frame), 64'd0);
    check("rst_core_reset", 64'(core_reset), 64'd1);
    @(posedge mclk); #1;
    reset = 1'b0;
    @(posedge mclk); #1;

    // Nominal job with clear-phase timing.
    do_start(16'd3);
    @(negedge mclk);
    check("clear_cycle1_core_reset", 64'(core_reset), 64'd1);
    check("clear_cycle1_busy", 64'(busy), 64'd1);
    @(posedge mclk); #1;
    @(negedge mclk);
    check("clear_cycle2_core_reset", 64'(core_reset), 64'd1);
    @(posedge mclk); #1;
    @(negedge mclk);
    check("load_core_reset", 64'(core_reset), 64'd0);
    check("load_s_tready", 64'(s_tready), 64'd1);
    @(posedge mclk); #1;
    job_body(jobs[0], 1'b0, 1'b0);

    for (int r = 0; r < 6; r++) begin
      do_start(jobs[r].np);
      job_body(jobs[r], jobs[r].stall, 1'b0);
    end

    // Zero training points: error and done on the next cycle, no core writes.
    w0 = wr_tot; d0 = done_tot;
    do_start(16'd0);
    @(negedge mclk);
    check("zero_done_next_cycle", 64'(done), 64'd1);
    check("zero_err_frame", 64'(err_frame), 64'd1);
    @(posedge mclk); #1;
    @(negedge mclk);
    check("zero_busy_after", 64'(busy), 64'd0);
    check("zero_done_count", 64'(done_tot - d0), 64'd1);
    check("zero_wr_en_count", 64'(wr_tot - w0), 64'd0);
    @(posedge mclk); #1;

    // Reset in the middle of STREAM, then a clean job.
    do_start(16'd3);
    send_beats(6, 0, 1'b0);
    reset = 1'b1;
    @(posedge mclk);
    @(negedge mclk);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_s_tready", 64'(s_tready), 64'd0);
    check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("midrst_done", 64'(done), 64'd0);
    check("midrst_err_frame", 64'(err_frame), 64'd0);
    check("midrst_core_reset", 64'(core_reset), 64'd1);
    @(posedge mclk); #1;
    reset = 1'b0;
    @(posedge mclk); #1;
    do_start(16'd3);
    job_body(jobs[0], 1'b0, 1'b0);

    // Start pulsed while busy must be ignored.
    b0 = busy_tot;
    do_start(16'd3);
    job_body(jobs[0], 1'b0, 1'b1);
`ifdef KNN_PERF_CNT_EN
    check("perf_cycles_job", 64'(perf_cycles), 64'(busy_tot - b0));
    repeat (5) begin
      @(posedge mclk); #1;
    end
    check("perf_cycles_hold", 64'(perf_cycles), 64'(busy_tot - b0));
`endif
    @(negedge mclk);
    check("idle_after_busy_start", 64'(busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
